alsu_op_sequencer: RTL
======================

ALSU_OP_SEQUENCER -- requirements
Module: alsu_op_sequencer

Interface
REQ-001 Parameters: none; datapath width fixed at 4 bits and register file fixed at 4 entries, matching the 4-bit ALSU it drives.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-006 cmd_op  input  4  ALSU select code, forwarded to alu_s; 4'b1110 = LOAD immediate.
REQ-007 cmd_ra / cmd_rb / cmd_rd  input  2 each  source A, source B, destination register index.
REQ-008 cmd_imm  input  4  immediate for LOAD.
REQ-009 alu_a / alu_b  output  4 each  operands to ALSU A/B.
REQ-010 alu_s  output  4  ALSU control S.
REQ-011 alu_cin  output  1  ALSU carry-in.
REQ-012 alu_f  input  4  ALSU result F (combinational from alu_a/alu_b/alu_s).
REQ-013 alu_cout  input  1  ALSU carry-out.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer takes result.
REQ-016 res_data  output  4  value written to R[rd].
REQ-017 flag_z / flag_c  output  1 each  zero and carry status flags.

Function
REQ-018 FSM SHALL have states IDLE, EXEC, DONE; cmd_ready = 1 only in IDLE.
REQ-019 IDLE: on cmd_valid && cmd_ready, op/ra/rb/rd/imm SHALL be latched and the FSM SHALL go to EXEC.
REQ-020 EXEC (exactly 1 cycle): alu_a = R[ra], alu_b = R[rb], alu_s = latched op; on exit edge R[rd] <= alu_f, res_data <= alu_f, flag_c <= alu_cout, flag_z <= (alu_f == 0); go to DONE.
REQ-021 LOAD (op 4'b1110) SHALL bypass the ALU: on EXEC exit R[rd] <= imm, res_data <= imm, flag_z updated, flag_c unchanged.
REQ-022 Op 4'b1111 SHALL be forwarded to the ALU unchanged; the sequencer captures whatever ALU returns.
REQ-023 DONE: res_valid = 1 and res_data stable until res_valid && res_ready; then go to IDLE.
REQ-024 Latency: command accepted at edge N; res_valid high from cycle N+2; minimum command period 3 cycles.
REQ-025 Outside EXEC, alu_a/alu_b/alu_s SHALL be 0.
REQ-026 ra == rd or rb == rd SHALL use the pre-write value; write occurs only on EXEC exit.
REQ-027 cmd_valid while not in IDLE SHALL be ignored (no latch, no side effects).
REQ-028 res_ready while not in DONE SHALL have no effect.
REQ-029 Arithmetic is modulo 16; no overflow detection beyond alu_cout.

Reset
REQ-030 rst SHALL force IDLE, R[0..3] = 0, res_data = 0, flag_z = 1, flag_c = 0, res_valid = 0, cmd_ready = 1 in the following cycle.
REQ-031 rst in EXEC or DONE SHALL discard the in-flight command; no register write on that edge.
REQ-032 rst SHALL take priority over every handshake on the same edge.

Configuration
REQ-033 Macro ALSU_SEQ_CARRY_CHAIN_EN defined: alu_cin = flag_c during EXEC (multi-word carry chaining); else 0.
REQ-034 Macro undefined: alu_cin SHALL be constant 0; all other behaviour is identical.

Verification
REQ-035 LOAD R0=9, LOAD R1=8, op 0000 ra=0 rb=1 rd=2 -> res_data=1, flag_c=1, flag_z=0, R2=1.
REQ-036 LOAD R0=5, op 1010 ra=0 rd=3 -> res_data=4'b1010; op 1100 ra=3 rd=3 -> res_data=4'b0101 (rotate-left, old R3 read).
REQ-037 op 1001 on R0=4'b1100, R1=4'b0011 -> res_data=0, flag_z=1, flag_c=0.
REQ-038 Hold res_ready=0 for 5 cycles in DONE with cmd_valid=1 -> res_valid/res_data stable, cmd_ready=0, no second command latched.
REQ-039 Assert rst during EXEC of op 0101 rd=1 (R1=7) -> R1=0 after reset, res_valid=0, flag_z=1, FSM in IDLE.
REQ-040 With ALSU_SEQ_CARRY_CHAIN_EN: flag_c=1 then EXEC -> alu_cin=1; without macro -> alu_cin=0.

Source files
------------

// File: rtl/alsu_op_sequencer.sv
// alsu_op_sequencer: drives a 4-bit ALSU from a small 4-entry register file.
// Each command goes through three steps. IDLE accepts and latches the command.
// EXEC presents the operands to the ALSU and writes the result back.
// DONE holds the result until the consumer takes it.
// Optional macro ALSU_SEQ_CARRY_CHAIN_EN feeds the carry flag into alu_cin
// during EXEC so that multi-word adds can chain their carries.
`timescale 1ns/1ps
module alsu_op_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic [1:0] cmd_rd,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_s,
  output logic       alu_cin,
  input  logic [3:0] alu_f,
  input  logic       alu_cout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       flag_z,
  output logic       flag_c
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] OP_LOAD = 4'b1110;

  state_t     state;
  state_t     state_next;

  logic [3:0] op_q;
  logic [3:0] imm_q;
  logic [1:0] ra_q;
  logic [1:0] rb_q;
  logic [1:0] rd_q;

  logic [3:0] regs [4];
  logic [3:0] res_q;
  logic       z_q;
  logic       c_q;

  logic [3:0] wb_data;

  // State register; reset wins over any handshake on the same edge
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: one cycle in EXEC, then wait in DONE for the consumer
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latch, loaded only on an accepted handshake in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      imm_q <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rd_q  <= '0;
    end else if (state == IDLE && cmd_valid) begin
      op_q  <= cmd_op;
      imm_q <= cmd_imm;
      ra_q  <= cmd_ra;
      rb_q  <= cmd_rb;
      rd_q  <= cmd_rd;
    end
  end

  // Writeback value: LOAD bypasses the ALSU, every other code takes its result
  always_comb begin
    wb_data = (op_q == OP_LOAD) ? imm_q : alu_f;
  end

  // Register file, result and flags update only on the edge leaving EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      res_q <= '0;
      z_q   <= 1'b1;
      c_q   <= 1'b0;
    end else if (state == EXEC) begin
      regs[rd_q] <= wb_data;
      res_q      <= wb_data;
      z_q        <= (wb_data == 4'd0);
      if (op_q != OP_LOAD) c_q <= alu_cout;
    end
  end

  // Outputs: ALSU inputs are live only in EXEC and read pre-write register values
  always_comb begin
    cmd_ready = (state == IDLE);
    res_valid = (state == DONE);
    alu_a     = '0;
    alu_b     = '0;
    alu_s     = '0;
    alu_cin   = 1'b0;
    if (state == EXEC) begin
      alu_a = regs[ra_q];
      alu_b = regs[rb_q];
      alu_s = op_q;
`ifdef ALSU_SEQ_CARRY_CHAIN_EN
      alu_cin = c_q;
`else
      alu_cin = 1'b0;
`endif
    end
  end

  assign res_data = res_q;
  assign flag_z   = z_q;
  assign flag_c   = c_q;

endmodule
